// File: rtl/booth_mult_scheduler_if.sv
// Request/result bundle shared by four requesters and the Booth multiplier scheduler.
// Ports: req/m_in/q_in flow from requesters; gnt/done/prdt/owner/busy flow back.
// master = requester side (testbench), slave = scheduler side.
interface booth_mult_scheduler_if;
  logic [3:0]  req;
  logic [31:0] m_in;
  logic [31:0] q_in;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic [15:0] prdt;
  logic [1:0]  owner;
  logic        busy;

  modport master (
    output req, m_in, q_in,
    input  gnt, done, prdt, owner, busy
  );

  modport slave (
    input  req, m_in, q_in,
    output gnt, done, prdt, owner, busy
  );
endinterface

// File: rtl/booth_mult_scheduler.sv
// Round-robin scheduler sharing one 8x8 signed radix-2 Booth multiplier among four requesters.
// Latency: gnt in cycle C, done in C+8, earliest next gnt in C+10; requests are only seen in IDLE.
// Ports: clk, reset (async, active-high), bus (slave modport: req/m_in/q_in in; gnt/done/prdt/owner/busy out).
module booth_mult_scheduler (
  input  logic                  clk,
  input  logic                  reset,
  booth_mult_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [1:0]  last_win;
  logic [1:0]  win;
  logic [1:0]  idx;
  logic        win_vld;

  logic [8:0]  m_reg;
  logic [8:0]  a_reg;
  logic [7:0]  q_reg;
  logic        q_m1;
  logic [2:0]  count;

  logic [8:0]  a_sum;
  logic [8:0]  a_nxt;
  logic [7:0]  q_nxt;
  logic        last_step;

  logic [3:0]  gnt_r;
  logic [3:0]  done_r;
  logic [15:0] prdt_r;
  logic [1:0]  owner_r;

  // Round-robin pick: scan starting one past the last winner, wrapping mod 4.
  always_comb begin
    win     = last_win;
    win_vld = 1'b0;
    idx     = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      idx = last_win + 2'(i);
      if (!win_vld && bus.req[idx]) begin
        win     = idx;
        win_vld = 1'b1;
      end
    end
  end

  // One Booth step: add/subtract M on the {Q0,Q-1} pair, then arithmetic
  // right shift of the concatenation {A,Q,Q-1}.
  always_comb begin
    case ({q_reg[0], q_m1})
      2'b10:   a_sum = a_reg - m_reg;
      2'b01:   a_sum = a_reg + m_reg;
      default: a_sum = a_reg;
    endcase
  end

  assign a_nxt     = {a_sum[8], a_sum[8:1]};
  assign q_nxt     = {a_sum[0], q_reg[7:1]};
  assign last_step = (count == 3'd7);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_vld) state_nxt = ITER;
      ITER:    if (last_step) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_win <= 2'd3;
      m_reg    <= 9'd0;
      a_reg    <= 9'd0;
      q_reg    <= 8'd0;
      q_m1     <= 1'b0;
      count    <= 3'd0;
      gnt_r    <= 4'd0;
      done_r   <= 4'd0;
      prdt_r   <= 16'd0;
      owner_r  <= 2'd0;
    end else begin
      // gnt and done are single-cycle pulses.
      gnt_r  <= 4'd0;
      done_r <= 4'd0;
      case (state)
        IDLE: begin
          if (win_vld) begin
            // M is sign-extended to 9 bits so that -128 can be negated in A.
            m_reg    <= {bus.m_in[{win, 3'b000} + 5'd7], bus.m_in[{win, 3'b000} +: 8]};
            q_reg    <= bus.q_in[{win, 3'b000} +: 8];
            a_reg    <= 9'd0;
            q_m1     <= 1'b0;
            count    <= 3'd0;
            gnt_r    <= 4'b0001 << win;
            owner_r  <= win;
            last_win <= win;
          end
        end
        ITER: begin
          a_reg <= a_nxt;
          q_reg <= q_nxt;
          q_m1  <= q_reg[0];
          count <= count + 3'd1;
          if (last_step) begin
            prdt_r <= {a_nxt[7:0], q_nxt};
            done_r <= 4'b0001 << owner_r;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.gnt   = gnt_r;
  assign bus.done  = done_r;
  assign bus.prdt  = prdt_r;
  assign bus.owner = owner_r;
  assign bus.busy  = (state != IDLE);

endmodule

// File: doc/booth_mult_scheduler.md
BOOTH_MULT_SCHEDULER -- requirements
Module: booth_mult_scheduler

Interface
REQ-001 SHALL have port clk, input, 1 bit: single rising-edge clock for all state.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port req, input, 4 bits: req[i] high means requester i wants one multiply.
REQ-004 SHALL have port m_in, input, 32 bits: requester i multiplicand on m_in[8i+7:8i], two's complement.
REQ-005 SHALL have port q_in, input, 32 bits: requester i multiplier on q_in[8i+7:8i], two's complement.
REQ-006 SHALL have port gnt, output, 4 bits: one-hot, one-cycle pulse when requester i's operands are captured.
REQ-007 SHALL have port done, output, 4 bits: one-hot, one-cycle pulse when requester i's product is valid on prdt.
REQ-008 SHALL have port prdt, output, 16 bits: signed product of the last completed operation.
REQ-009 SHALL have port owner, output, 2 bits: index of the requester currently or most recently served.
REQ-010 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.

Function
REQ-011 SHALL implement states IDLE, ITER and DONE in a registered state machine.
REQ-012 In IDLE with any req bit high at a clock edge, the block SHALL select a winner, capture its operands, set owner, load count=0, move to ITER, and assert gnt[winner] for exactly the following cycle.
REQ-013 Arbitration SHALL be round-robin: priority starts at (last winner + 1) mod 4 and wraps; the last winner is updated only on grant.
REQ-014 In IDLE with req all zero, the block SHALL remain in IDLE with gnt=0.
REQ-015 ITER SHALL perform one radix-2 Booth step per cycle: on pair {Q0,Q-1} = 10 subtract M, 01 add M, 00/11 no-op; then arithmetic right shift of {A,Q,Q-1}.
REQ-016 Accumulator A SHALL be 9 bits with sign-extended M so that M = -128 gives a correct result.
REQ-017 After the 8th ITER step the block SHALL register prdt = {A[7:0],Q} (the 16-bit signed product), move to DONE, and assert done[owner] for that DONE cycle only.
REQ-018 DONE SHALL return to IDLE on the next edge unconditionally; no arbitration occurs in DONE or ITER.
REQ-019 Latency SHALL be: gnt cycle = C, done cycle = C+8, earliest next gnt = C+10.
REQ-020 req and operand bits SHALL be ignored outside IDLE; a req raised and dropped entirely while busy SHALL never be granted.
REQ-021 Operands SHALL be sampled only on the granting edge; later changes to m_in/q_in SHALL not affect the running operation.
REQ-022 prdt and owner SHALL hold their values until the next DONE or grant respectively.
REQ-023 gnt and done SHALL never be asserted in the same cycle and each SHALL have at most one bit set.

Reset
REQ-024 While reset is high, the block SHALL immediately force state=IDLE, gnt=0, done=0, prdt=0, owner=0, busy=0, count=0, and datapath registers to 0.
REQ-025 Reset SHALL set last winner = 3 so that requester 0 has the highest priority first.
REQ-026 A reset mid-ITER SHALL abandon the operation with no done pulse; service SHALL resume from IDLE after reset is released.

Verification
REQ-027 Single request: req=0001, M=3, Q=8'hFC -> gnt=0001 in cycle C, done=0001 in C+8, prdt=16'hFFF4, owner=0.
REQ-028 Corners: M=8'h80, Q=8'h80 -> prdt=16'h4000; M=8'h7F, Q=8'h80 -> prdt=16'hC080; M=0, Q=8'h55 -> prdt=0.
REQ-029 Fairness: req=1111 held continuously -> grants in order 0,1,2,3,0 spaced 10 cycles apart, with each done matching the owner.
REQ-030 Mid-op reset: reset pulsed during ITER -> all outputs 0 at once, no done; after release with req=0010 -> requester 1 granted next.
REQ-031 Ignored request: req[2] pulsed only during ITER for requester 0 -> no gnt[2] ever; operand changes on m_in[7:0] after gnt -> prdt unaffected.
